uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the peripheral bus: configurable data width, parity and stop bits, with a FIFO of received characters and sticky error flags.
Generalises the single-byte 8N1 receiver so the CPU can absorb bursts without polling each character.
Sits between the external RX pin and the UART register interface. The register interface pops characters with rd_en.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz.
BAUD_RATE, 115200, line rate in bits/s. DIVIDER = CLK_FREQ/BAUD_RATE (integer divide); HALF = DIVIDER/2.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
STOP_BITS, 1, stop bits checked: 1 or 2.
FIFO_DEPTH, 16, FIFO entries; power of two, at least 2. AW = $clog2(FIFO_DEPTH).

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
rx  in  1  asynchronous UART line, idle high
rd_en  in  1  pop head entry this cycle (ignored when empty)
err_clr  in  1  clear sticky error flags
rd_data  out  8  head entry data, LSB-aligned, upper bits zero; valid while !rx_empty
rd_perr  out  1  head entry parity-error tag; valid while !rx_empty
rx_empty  out  1  FIFO empty
rx_full  out  1  FIFO full
rx_count  out  AW+1  number of entries held, 0..FIFO_DEPTH
frame_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: a parity mismatch was received
overrun  out  1  sticky: a good character arrived while the FIFO was full

Behaviour:
- Reset (rst_n=0 on a rising edge, at any time, including mid-frame):
  - rx synchroniser flops go to 1; state goes to IDLE; counters go to 0.
  - FIFO is emptied: rx_empty=1, rx_full=0, rx_count=0.
  - rd_data=0, rd_perr=0; frame_err, parity_err and overrun all 0.
- Input: rx passes through a 2-flop synchroniser (rs). All decisions use rs.
- State machine:
  - IDLE: baud counter held at 0. rs=0 -> START.
  - START: count to HALF-1. If rs=0 there, reset counter and go to DATA; else return to IDLE (glitch reject).
  - DATA: sample on tick (counter==DIVIDER-1, then counter reset). Bits arrive LSB first. After DATA_BITS samples go to PARITY if PARITY!=0, else to STOP.
  - PARITY: one tick, sample parity bit. Even mode: the XOR of data bits plus the parity bit must be 0. Odd mode: it must be 1. Mismatch sets the entry tag.
  - STOP: one tick per stop bit. Any stop sample low is a framing error -> WAIT_HIGH. After the final good stop sample -> IDLE immediately (mid-stop-bit), so back-to-back frames are received.
  - WAIT_HIGH: stay until rs=1, then IDLE. A held-low line (break) produces exactly one frame_err and no false characters.
- Push: on the final good stop sample, the character is written to the FIFO, tagged with its parity result.
  - Framing-error characters are discarded and set frame_err.
  - A parity-error character is still pushed (rd_perr=1) and sets parity_err.
- Latency: rx_empty falls and rd_data becomes valid on the clk following the final stop-bit sample.
- FIFO (show-ahead): rd_data and rd_perr reflect the head entry combinationally from registered storage. Pointers wrap modulo FIFO_DEPTH.
- Boundary conditions:
  - Push while full, no pop: character dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle while full: both take effect; count unchanged; no overrun.
  - Push and pop in the same cycle while empty: push only.
  - Pop while empty: ignored.
- Sticky flags: cleared by err_clr. If a set event and err_clr occur in the same cycle, the set wins.

Optional Feature:
Macro: UART_RX_MAJORITY_EN.
- Defined: every data, parity and stop sample is the 2-of-3 majority of rs at tick-2, tick-1 and tick. The START mid-check uses the same vote at HALF-1. Requires DIVIDER >= 4.
- Undefined: single sample of rs at the tick, as above.
- Timing and latency are identical in both builds.

Test Plan:
- All tests use CLK_FREQ=1000000, BAUD_RATE=100000 (DIVIDER=10) unless stated.
- Defaults (8N1): send 0xA5, 0x3C back-to-back. Required: rx_count reaches 2; rd_data=0xA5 then 0x3C on successive rd_en pulses; rd_perr=0; all error flags 0.
- PARITY=1, DATA_BITS=7: send 0x41 with correct parity bit 0 -> rd_perr=0. Then send 0x41 with parity bit 1 -> entry pushed with rd_perr=1 and parity_err=1. err_clr pulse -> parity_err=0.
- FIFO_DEPTH=4: send 5 characters without reading. Required: rx_full=1, rx_count=4, overrun=1, first four characters read back in order, fifth lost. Repeat with rd_en asserted on the 5th push cycle -> no overrun.
- STOP_BITS=2: second stop bit driven low -> frame_err=1, nothing pushed. Then hold rx low for 30 bit times -> exactly one frame_err event and rx_empty stays 1. Release the line, send 0x55 -> received correctly.
- 0.5-bit low glitch on idle line -> nothing pushed. Assert rst_n=0 mid-frame of 0xFF -> everything returns to reset values. The next frame 0x12 is received correctly.
- With UART_RX_MAJORITY_EN: a one-clock-wide inverted pulse at the centre of each bit of 0x96 -> 0x96 received, no errors.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with parity/stop checking, a show-ahead character FIFO and sticky error flags.
// Define UART_RX_MAJORITY_EN to take every bit sample as a 2-of-3 vote around the tick.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        rd_en,
    input  logic        err_clr,
    output logic [7:0]  rd_data,
    output logic        rd_perr,
    output logic        rx_empty,
    output logic        rx_full,
    output logic [AW:0] rx_count,
    output logic        frame_err,
    output logic        parity_err,
    output logic        overrun
);

    localparam int DIVIDER = CLK_FREQ / BAUD_RATE;
    localparam int HALF    = DIVIDER / 2;
    localparam int CW      = $clog2(DIVIDER + 1);

    localparam logic [CW-1:0] TICK      = CW'(DIVIDER - 1);
    localparam logic [CW-1:0] MID       = CW'(HALF - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY == 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_WAITH = 3'd5;

    logic                 r_s1;
    logic                 r_rs;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bitn;
    logic                 r_stopn;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_pbad;

    logic                 w_samp;
    logic                 w_tick;
    logic                 w_push;
    logic                 w_ferr;

`ifdef UART_RX_MAJORITY_EN
    logic r_h1;
    logic r_h2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h1 <= 1'b1;
            r_h2 <= 1'b1;
        end else begin
            r_h1 <= r_rs;
            r_h2 <= r_h1;
        end
    end

    assign w_samp = (r_rs & r_h1) | (r_rs & r_h2) | (r_h1 & r_h2);
`else
    assign w_samp = r_rs;
`endif

    assign w_tick = (r_cnt == TICK);
    assign w_push = (r_state == S_STOP) && w_tick && w_samp
                 && (r_stopn == LAST_STOP);
    assign w_ferr = (r_state == S_STOP) && w_tick && !w_samp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= 1'b1;
            r_rs    <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_stopn <= 1'b0;
            r_shift <= '0;
            r_pbad  <= 1'b0;
        end else begin
            r_s1 <= rx;
            r_rs <= r_s1;
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rs) r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == MID) begin
                        r_cnt   <= '0;
                        r_bitn  <= '0;
                        r_stopn <= 1'b0;
                        r_pbad  <= 1'b0;
                        r_state <= w_samp ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_samp, r_shift[DATA_BITS-1:1]};
                        r_bitn  <= r_bitn + 3'd1;
                        if (r_bitn == LAST_BIT)
                            r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_PAR: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_pbad  <= (^r_shift) ^ w_samp ^ ODD;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        // Leave mid-stop-bit so a following start edge is not missed
                        if (!w_samp)
                            r_state <= S_WAITH;
                        else if (r_stopn == LAST_STOP)
                            r_state <= S_IDLE;
                        else
                            r_stopn <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAITH: begin
                    r_cnt <= '0;
                    if (r_rs) r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    logic [DATA_BITS-1:0] r_mem  [FIFO_DEPTH];
    logic                 r_memp [FIFO_DEPTH];
    logic [AW-1:0]        r_wp;
    logic [AW-1:0]        r_rp;
    logic [AW:0]          r_count;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_ovr;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_ovr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = rd_en && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_ovr   = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst_n && w_wr) begin
            r_mem[r_wp]  <= r_shift;
            r_memp[r_wp] <= r_pbad;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_wr)  r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            r_ferr <= w_ferr | (r_ferr & ~err_clr);
            r_perr <= (w_push & r_pbad) | (r_perr & ~err_clr);
            r_ovr  <= w_ovr | (r_ovr & ~err_clr);
        end
    end

    assign rd_data    = w_empty ? 8'h00 : 8'(r_mem[r_rp]);
    assign rd_perr    = !w_empty && r_memp[r_rp];
    assign rx_empty   = w_empty;
    assign rx_full    = w_full;
    assign rx_count   = r_count;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;

endmodule
